// File: rtl/sparse_chunk_writer_if.sv
// Dense input beats and compressed write beats of the sparse chunk writer.
// slave = the writer itself, master = the producer/consumer side driving it.
interface sparse_chunk_writer_if #(
  parameter int BUS_SIZE = 32,
  parameter int MEM_SIZE = 128
);
  localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
  localparam int CW         = $clog2(WR_CYC_NUM);
  localparam int NW         = $clog2(BUS_SIZE) + 1;

  logic                     flush_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [BUS_SIZE-1:0][7:0] in_data_i;
  logic [1:0]               bank_release_i;
  logic [BUS_SIZE-1:0]      wr_sparsemap_o;
  logic [BUS_SIZE-1:0][7:0] wr_nonzero_data_o;
  logic                     wr_valid_o;
  logic [CW-1:0]            wr_count_o;
  logic                     wr_sel_o;
  logic [NW-1:0]            nz_count_o;
  logic                     chunk_done_o;
  logic [1:0]               bank_full_o;

  modport slave (
    input  flush_i, in_valid_i, in_data_i, bank_release_i,
    output in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o,
           wr_count_o, wr_sel_o, nz_count_o, chunk_done_o, bank_full_o
  );

  modport master (
    output flush_i, in_valid_i, in_data_i, bank_release_i,
    input  in_ready_o, wr_sparsemap_o, wr_nonzero_data_o, wr_valid_o,
           wr_count_o, wr_sel_o, nz_count_o, chunk_done_o, bank_full_o
  );
endinterface

// File: rtl/sparse_chunk_writer.sv
// Packs nonzero bytes of each dense beat and streams them as chunks of
// WR_CYC_NUM beats into two ping-pong banks, stalling when the next bank is full.
module sparse_chunk_writer #(
  parameter int BUS_SIZE = 32,
  parameter int MEM_SIZE = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sparse_chunk_writer_if.slave  bus
);
  localparam int WR_CYC_NUM     = MEM_SIZE / BUS_SIZE;
  localparam int CW             = $clog2(WR_CYC_NUM);
  localparam int NW             = $clog2(BUS_SIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(WR_CYC_NUM - 1);

  typedef enum logic {FILL, STALL} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic                     sel_q;
  logic [1:0]               full_q;
  logic                     run_q;
  logic                     ready, accept, last_beat;
  logic [1:0]               full_set;
  logic [BUS_SIZE-1:0]      map;
  logic [BUS_SIZE-1:0][7:0] packed_d;
  logic [NW-1:0]            nz;

  // nz doubles as the next free output slot while scanning upward
  always_comb begin
    map      = '0;
    packed_d = '0;
    nz       = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (bus.in_data_i[i] != 8'h00) begin
        map[i]                = 1'b1;
        packed_d[nz[NW-2:0]]  = bus.in_data_i[i];
        nz                    = nz + NW'(1);
      end
    end
  end

  // Banks are only checked at chunk start; a started chunk always completes.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      FILL: begin
        if (bus.flush_i)                       state_d = FILL;
        else if (cnt_q == '0 && full_q[sel_q]) state_d = STALL;
        else                                   ready   = run_q;
      end
      STALL: begin
        if (bus.flush_i || !full_q[sel_q])     state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign accept         = bus.in_valid_i & ready;
  assign last_beat      = (cnt_q == LAST);
  assign full_set       = (accept && last_beat) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.in_ready_o = ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q               <= FILL;
      cnt_q                 <= '0;
      sel_q                 <= 1'b0;
      full_q                <= 2'b00;
      run_q                 <= 1'b0;
      bus.wr_valid_o        <= 1'b0;
      bus.wr_sparsemap_o    <= '0;
      bus.wr_nonzero_data_o <= '0;
      bus.wr_count_o        <= '0;
      bus.wr_sel_o          <= 1'b0;
      bus.nz_count_o        <= '0;
      bus.chunk_done_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      // set beats release when both hit the same bank
      full_q  <= (full_q & ~bus.bank_release_i) | full_set;
      if (bus.flush_i) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + CW'(1);
        if (last_beat) sel_q <= ~sel_q;
      end
      bus.wr_valid_o        <= accept;
      bus.wr_sparsemap_o    <= accept ? map      : '0;
      bus.wr_nonzero_data_o <= accept ? packed_d : '0;
      bus.wr_count_o        <= accept ? cnt_q    : '0;
      bus.wr_sel_o          <= accept & sel_q;
      bus.nz_count_o        <= accept ? nz       : '0;
      bus.chunk_done_o      <= accept & last_beat;
    end
  end

  assign bus.bank_full_o = full_q;
endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Bench for sparse_chunk_writer: vector table plus hand sequences for stall,
// release, flush and async reset; write beats are checked against a scoreboard.
module tb_sparse_chunk_writer;
  localparam int BUS = 32;
  localparam int MEM = 128;

  typedef logic [BUS-1:0][7:0] beat_t;
  typedef struct {
    beat_t          din;
    logic [BUS-1:0] map;
    logic [5:0]     nz;
    beat_t          dout;
  } vec_t;
  typedef struct {
    logic [BUS-1:0] map;
    logic [5:0]     nz;
    beat_t          data;
    logic [1:0]     cnt;
    logic           sel;
    logic           done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sparse_chunk_writer_if #(.BUS_SIZE(BUS), .MEM_SIZE(MEM)) bus ();
  sparse_chunk_writer #(.BUS_SIZE(BUS), .MEM_SIZE(MEM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] m_cnt;
  logic       m_sel;
  logic [1:0] m_bf;
  vec_t       tv[8];

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference compression: k-th nonzero byte goes to slot k
  task automatic ref_c(input beat_t d, output logic [BUS-1:0] map, output logic [5:0] nz,
                       output beat_t o);
    int k;
    k = 0; map = '0; o = '0;
    for (int i = 0; i < BUS; i++)
      if (d[i] != 8'h00) begin
        map[i] = 1'b1;
        o[k]   = d[i];
        k++;
      end
    nz = 6'(k);
  endtask

  task automatic push_exp(input logic [BUS-1:0] map, input logic [5:0] nz, input beat_t d,
                          input logic [1:0] rel);
    exp_t e;
    e.map = map; e.nz = nz; e.data = d;
    e.cnt = m_cnt; e.sel = m_sel; e.done = (m_cnt == 2'd3);
    sb.push_back(e);
    m_bf = m_bf & ~rel;
    if (e.done) begin
      m_bf[m_sel] = 1'b1;
      m_sel       = ~m_sel;
    end
    m_cnt = m_cnt + 2'd1;
  endtask

  task automatic send_beat(input beat_t d, input logic [BUS-1:0] map, input logic [5:0] nz,
                           input beat_t o, input logic [1:0] rel);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.in_data_i = d; bus.bank_release_i = rel;
    #1;
    while (!bus.in_ready_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.in_ready_o) begin
      check("accept_timeout", 320'(0), 320'(1));
      bus.in_valid_i = 1'b0; bus.bank_release_i = 2'b00;
    end else begin
      push_exp(map, nz, o, rel);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0; bus.bank_release_i = 2'b00;
    end
  endtask

  task automatic rand_beat(output beat_t d);
    for (int i = 0; i < BUS; i++)
      d[i] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic send_rand(input logic [1:0] rel);
    beat_t d, o;
    logic [BUS-1:0] m;
    logic [5:0] z;
    rand_beat(d);
    ref_c(d, m, z, o);
    send_beat(d, m, z, o, rel);
  endtask

  // Output monitor: every write beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_valid_o) begin
        if (sb.size() == 0) check("unexpected_beat", 320'(1), 320'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          check("beat", 320'({bus.wr_sparsemap_o, bus.nz_count_o, bus.wr_nonzero_data_o,
                               bus.wr_count_o, bus.wr_sel_o, bus.chunk_done_o}),
                        320'({e.map, e.nz, e.data, e.cnt, e.sel, e.done}));
        end
      end else begin
        check("idle_zero", 320'({bus.wr_sparsemap_o, bus.nz_count_o, bus.wr_nonzero_data_o,
                                 bus.wr_count_o, bus.wr_sel_o, bus.chunk_done_o}), 320'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t d;
    int    n;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.bank_release_i = 2'b00;
    m_cnt = 2'd0; m_sel = 1'b0; m_bf = 2'b00;

    for (int i = 0; i < 8; i++) begin
      tv[i].din = '0; tv[i].map = '0; tv[i].nz = '0; tv[i].dout = '0;
    end
    tv[0].din[3] = 8'h11; tv[0].din[7] = 8'h22;
    tv[0].map = 32'h0000_0088; tv[0].nz = 6'd2; tv[0].dout[0] = 8'h11; tv[0].dout[1] = 8'h22;
    // tv[1] all zero: everything stays 0
    tv[2].din = {BUS{8'hFF}}; tv[2].map = 32'hFFFF_FFFF; tv[2].nz = 6'd32; tv[2].dout = {BUS{8'hFF}};
    tv[3].din[31] = 8'h5A; tv[3].map = 32'h8000_0000; tv[3].nz = 6'd1; tv[3].dout[0] = 8'h5A;
    tv[4].din[0] = 8'h01; tv[4].map = 32'h0000_0001; tv[4].nz = 6'd1; tv[4].dout[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      tv[5].din[2*i] = 8'(2*i + 1); tv[5].dout[i] = 8'(2*i + 1);
      tv[6].din[16+i] = 8'h90 + 8'(i); tv[6].dout[i] = 8'h90 + 8'(i);
    end
    tv[5].map = 32'h5555_5555; tv[5].nz = 6'd16;
    tv[6].map = 32'hFFFF_0000; tv[6].nz = 6'd16;
    for (int i = 1; i < 32; i++) begin
      tv[7].din[i] = 8'(i); tv[7].dout[i-1] = 8'(i);
    end
    tv[7].map = 32'hFFFF_FFFE; tv[7].nz = 6'd31;

    // Reset state
    #12;
    check("rst_ready", 320'(bus.in_ready_o), 320'(0));
    check("rst_outputs", 320'({bus.wr_valid_o, bus.chunk_done_o, bus.bank_full_o, bus.wr_count_o,
                                bus.wr_sel_o, bus.nz_count_o}), 320'(0));
    @(negedge clk); rst = 1'b0; #1;
    check("ready_before_edge", 320'(bus.in_ready_o), 320'(0));
    @(posedge clk); #1;
    check("ready_after_edge", 320'(bus.in_ready_o), 320'(1));

    // Table vectors, 8 back-to-back beats: two full chunks into banks 0 and 1
    for (int i = 0; i < 8; i++) send_beat(tv[i].din, tv[i].map, tv[i].nz, tv[i].dout, 2'b00);
    check("bank_full_both", 320'(bus.bank_full_o), 320'(2'b11));

    // 9th beat stalls
    rand_beat(d);
    @(negedge clk); bus.in_valid_i = 1'b1; bus.in_data_i = d;
    for (int i = 0; i < 3; i++) begin
      #1; check("stall_ready", 320'(bus.in_ready_o), 320'(0));
      @(negedge clk);
    end
    bus.in_valid_i = 1'b0; bus.bank_release_i = 2'b01;
    @(negedge clk); bus.bank_release_i = 2'b00; m_bf = 2'b10;
    #1; check("release_bank0", 320'(bus.bank_full_o), 320'(2'b10));
    n = 0;
    while (!bus.in_ready_o && n < 3) begin @(negedge clk); #1; n++; end
    check("ready_after_release", 320'({bus.in_ready_o, n <= 2}), 320'(2'b11));
    send_rand(2'b00);                       // sel 0, count 0

    // Flush after two beats of a chunk
    send_rand(2'b00);
    rand_beat(d);
    @(negedge clk); bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = d;
    #1; check("flush_squash", 320'(bus.in_ready_o), 320'(0));
    @(posedge clk); #1; bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; m_cnt = 2'd0;
    for (int i = 0; i < 4; i++) send_rand(2'b00);
    check("bank_full_after_flush_chunk", 320'(bus.bank_full_o), 320'(2'b11));

    // Release both, then release collides with the set of bank 1
    @(negedge clk); bus.bank_release_i = 2'b11;
    @(posedge clk); #1; bus.bank_release_i = 2'b00; m_bf = 2'b00;
    check("release_both", 320'(bus.bank_full_o), 320'(2'b00));
    for (int i = 0; i < 3; i++) send_rand(2'b00);
    send_rand(2'b10);
    check("set_wins", 320'(bus.bank_full_o), 320'(2'b10));
    @(negedge clk); bus.bank_release_i = 2'b01;
    @(posedge clk); #1; bus.bank_release_i = 2'b00;
    check("release_not_full", 320'(bus.bank_full_o), 320'(2'b10));

    // Async reset mid-chunk
    send_rand(2'b00);
    send_rand(2'b00);
    #1; rst = 1'b1; #1;
    check("async_rst_outputs", 320'({bus.wr_valid_o, bus.chunk_done_o, bus.bank_full_o,
                                     bus.wr_count_o, bus.wr_sel_o, bus.nz_count_o,
                                     bus.wr_sparsemap_o, bus.in_ready_o}), 320'(0));
    check("async_rst_data", 320'(bus.wr_nonzero_data_o), 320'(0));
    sb.delete(); m_cnt = 2'd0; m_sel = 1'b0; m_bf = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    check("ready_before_edge2", 320'(bus.in_ready_o), 320'(0));
    @(posedge clk); #1;
    check("ready_after_edge2", 320'(bus.in_ready_o), 320'(1));
    send_rand(2'b00);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 320'(sb.size()), 320'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
